multi_debounce_timer: RTL and testbench

- Parametrised N-channel button clean-up block with per-channel synchroniser, debounce counter and four-state FSM.
- Replaces the single fixed 8 ms counter/comparator plus external state machine.
- Outputs a debounced level and single-cycle rise/fall pulses per channel.
- Sits between raw board buttons and all downstream control logic.

---
 rtl/multi_debounce_timer.sv | 108 ++++++++++
 tb/tb_multi_debounce_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce_timer.sv
// N-channel button debouncer: synchroniser, per-channel qualify counter and 4-state FSM.
// Clean level changes SYNC_STAGES+COUNT_MAX+2 cycles after a stable raw edge; no backpressure.
module multi_debounce_timer #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_MAX   = 39999,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_clean,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(COUNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
    state_t                 state_q [CHANNELS];
    state_t                 state_d [CHANNELS];
    logic [CNT_W-1:0]       cnt_q   [CHANNELS];
    logic [CNT_W-1:0]       cnt_d   [CHANNELS];

    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] clean_q, clean_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic                busy_q, busy_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Dropping en abandons any qualification in progress and falls back to the stable level.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                ST_LOW: begin
                    if (en && sync_s[i]) state_d[i] = ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    if (!en || !sync_s[i])        state_d[i] = ST_LOW;
                    else if (cnt_q[i] == CNT_TERM) state_d[i] = ST_HIGH;
                    else                           cnt_d[i]   = cnt_q[i] + CNT_ONE;
                end
                ST_HIGH: begin
                    if (en && !sync_s[i]) state_d[i] = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!en || sync_s[i])          state_d[i] = ST_HIGH;
                    else if (cnt_q[i] == CNT_TERM) state_d[i] = ST_LOW;
                    else                           cnt_d[i]   = cnt_q[i] + CNT_ONE;
                end
                default: state_d[i] = ST_LOW;
            endcase
            clean_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_WAIT_LOW);
            rise_d[i]  = (state_q[i] == ST_WAIT_HIGH) && (state_d[i] == ST_HIGH);
            fall_d[i]  = (state_q[i] == ST_WAIT_LOW) && (state_d[i] == ST_LOW);
            busy_d     = busy_d || (state_d[i] == ST_WAIT_HIGH) || (state_d[i] == ST_WAIT_LOW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign btn_clean = clean_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multi_debounce_timer.sv
// Randomised and directed bench for multi_debounce_timer against a run-length reference model.
module tb_multi_debounce_timer;

    localparam int CH = 4;
    localparam int CM = 9;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CH-1:0] btn_raw;
    logic [CH-1:0] btn_clean, btn_rise, btn_fall;
    logic          busy;

    logic       en_b = 1'b1;
    logic [0:0] raw_b;
    logic [0:0] clean_b, rise_b, fall_b;
    logic       busy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_debounce_timer #(.CHANNELS(CH), .COUNT_MAX(CM), .CNT_W(4), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw),
        .btn_clean(btn_clean), .btn_rise(btn_rise), .btn_fall(btn_fall), .busy(busy)
    );

    multi_debounce_timer #(.CHANNELS(1), .COUNT_MAX(39999), .CNT_W(16), .SYNC_STAGES(2)) dut_big (
        .clk(clk), .rst(rst), .en(en_b), .btn_raw(raw_b),
        .btn_clean(clean_b), .btn_rise(rise_b), .btn_fall(fall_b), .busy(busy_b)
    );

    // Reference: a channel flips once its synchronised input has disagreed with the
    // clean level for COUNT_MAX+2 consecutive enabled edges.
    logic [CH-1:0] m_sync[$];
    logic [CH-1:0] m_clean, m_rise, m_fall;
    logic          m_busy;
    int            m_run [CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        logic [CH-1:0] s;
        if (rst) begin
            m_sync = {};
            for (int k = 0; k < SS; k++) m_sync.push_front('0);
            m_clean = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
            return;
        end
        s = m_sync.pop_back();
        m_sync.push_front(btn_raw);
        m_rise = '0; m_fall = '0; m_busy = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (en && (s[c] != m_clean[c])) m_run[c]++;
            else                            m_run[c] = 0;
            if (m_run[c] == CM + 2) begin
                m_clean[c] = ~m_clean[c];
                if (m_clean[c]) m_rise[c] = 1'b1;
                else            m_fall[c] = 1'b1;
                m_run[c] = 0;
            end
            if (m_run[c] > 0) m_busy = 1'b1;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("clean", 32'(btn_clean), 32'(m_clean));
        chk("rise",  32'(btn_rise),  32'(m_rise));
        chk("fall",  32'(btn_fall),  32'(m_fall));
        chk("busy",  32'(busy),      32'(m_busy));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Counts edges until btn_clean[ch]==val; also tallies rise/fall pulses seen on ch.
    task automatic wait_clean(input int ch, input logic val, input int bound,
                              output int n, output int rises, output int falls);
        n = 0; rises = 0; falls = 0;
        while (n < bound) begin
            tick();
            n++;
            if (btn_rise[ch]) rises++;
            if (btn_fall[ch]) falls++;
            if (btn_clean[ch] == val) break;
        end
    endtask

    initial begin
        int n, r, f, rt, ft;
        logic [CH-1:0] rv;
        rst = 1'b1; en = 1'b1; btn_raw = '0; raw_b = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_clean", 32'(btn_clean), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        rst = 1'b0;
        ticks(3);

        // single press on channel 0
        btn_raw[0] = 1'b1;
        wait_clean(0, 1'b1, 40, n, r, f);
        chk("t1_latency", 32'(n), 32'd13);
        chk("t1_rise", 32'(btn_rise), 32'b0001);

        // bounce on channel 1
        btn_raw[1] = 1'b1; ticks(5);
        btn_raw[1] = 1'b0; ticks(2);
        btn_raw[1] = 1'b1;
        wait_clean(1, 1'b1, 40, n, r, f);
        chk("t2_latency", 32'(n), 32'd13);
        rt = r;
        for (int k = 0; k < 6; k++) begin tick(); if (btn_rise[1]) rt++; end
        chk("t2_rise_count", 32'(rt), 32'd1);

        // release, then a short glitch that must be filtered
        btn_raw[0] = 1'b0;
        wait_clean(0, 1'b0, 40, n, r, f);
        chk("t3_latency", 32'(n), 32'd13);
        chk("t3_fall", 32'(btn_fall), 32'b0001);
        btn_raw[0] = 1'b1; ticks(20);
        btn_raw[0] = 1'b0; ticks(3);
        btn_raw[0] = 1'b1;
        ft = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (btn_fall[0]) ft++; end
        chk("t3_glitch_clean", 32'(btn_clean[0]), 32'd1);
        chk("t3_glitch_fall", 32'(ft), 32'd0);

        // simultaneous press
        btn_raw[3:2] = 2'b11;
        wait_clean(2, 1'b1, 40, n, r, f);
        chk("t4_rise_pair", 32'(btn_rise), 32'b1100);
        tick();
        chk("t4_clean_pair", 32'(btn_clean[3:2]), 32'b11);

        // reset mid-qualification
        btn_raw = '0; ticks(20);
        btn_raw[0] = 1'b1; ticks(8);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_outs", 32'({btn_clean, btn_rise, btn_fall, busy}), 32'h0);
        wait_clean(0, 1'b1, 40, n, r, f);
        chk("t5_latency", 32'(n), 32'd13);

        // enable drop mid WAIT_LOW
        btn_raw[0] = 1'b0; ticks(6);
        en = 1'b0; tick();
        chk("t6_hold_clean", 32'(btn_clean[0]), 32'd1);
        chk("t6_no_fall", 32'(btn_fall[0]), 32'd0);
        en = 1'b1;
        wait_clean(0, 1'b0, 40, n, r, f);
        chk("t6_requal", 32'(n), 32'd11);
        chk("t6_fall_count", 32'(f), 32'd1);

        // randomised traffic
        for (int it = 0; it < 500; it++) begin
            rv = btn_raw;
            for (int c = 0; c < CH; c++) if ($urandom_range(3) == 0) rv[c] = ~rv[c];
            btn_raw = rv;
            en  = ($urandom_range(9) != 0);
            rst = ($urandom_range(49) == 0);
            ticks(1 + $urandom_range(14));
            rst = 1'b0;
        end

        // full-size timing
        en = 1'b1; btn_raw = '0;
        rst = 1'b1; tick(); rst = 1'b0; ticks(2);
        raw_b = 1'b1;
        n = 0;
        while (n < 41000) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (clean_b[0]) break;
        end
        chk("big_latency", 32'(n), 32'd40003);
        chk("big_rise", 32'(rise_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
